// File: rtl/vector_lsu.sv
// Vector load/store sequencer: walks one RVV memory instruction element by element,
// moving data between a 32-bit data-memory port and an element-granular VRF port.
module vector_lsu #(
    parameter int VLEN   = 128,
    parameter int ADDR_W = 32,
    parameter int IDXW   = $clog2(VLEN/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_store,
    input  logic              i_stride_en,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [31:0]       i_stride,
    input  logic [10:0]       i_sew,
    input  logic [31:0]       i_venum,
    input  logic [4:0]        i_vda,
    input  logic              i_exstall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_read_en,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_memaddr,
    output logic [31:0]       o_write_data,
    output logic [3:0]        o_byte_en,
    input  logic [31:0]       i_read_data,
    output logic [4:0]        o_vrf_reg,
    output logic [IDXW-1:0]   o_vrf_idx,
    output logic              o_vrf_we,
    output logic [31:0]       o_vrf_wdata,
    input  logic [31:0]       i_vrf_rdata
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW_BAD} sew_t;

    function automatic sew_t decode_sew(input logic [10:0] sew);
        case (sew)
            11'h008: decode_sew = SEW8;
            11'h010: decode_sew = SEW16;
            11'h020: decode_sew = SEW32;
            default: decode_sew = SEW_BAD;
        endcase
    endfunction

    state_t            state, state_next;
    sew_t              sew_q;
    logic              store_q, stride_en_q, err_q;
    logic [ADDR_W-1:0] addr_q, step;
    logic [31:0]       stride_q, venum_q, cnt_q;
    logic [4:0]        vreg_q;
    logic [IDXW-1:0]   idx_q, last_idx;
    logic [1:0]        lane;
    logic [31:0]       load_elem, store_word;
    logic [3:0]        store_be;
    logic              misaligned, last_elem, run, fire;

    assign lane      = addr_q[1:0];
    assign last_elem = (cnt_q == venum_q - 32'd1);
    assign run       = (state == RUN);
    assign fire      = run && !i_exstall && !misaligned;

    // Per-SEW lane extraction, store replication, address step and register-group size.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        load_elem  = i_read_data;
        store_word = i_vrf_rdata;
        store_be   = 4'b1111;
        step       = ADDR_W'(4);
        last_idx   = IDXW'(VLEN/32 - 1);
        misaligned = (lane != 2'b00);
        case (sew_q)
            SEW8: begin
                load_elem  = {24'd0, i_read_data[{lane, 3'b000} +: 8]};
                store_word = {4{i_vrf_rdata[7:0]}};
                store_be   = 4'b0001 << lane;
                step       = ADDR_W'(1);
                last_idx   = IDXW'(VLEN/8 - 1);
                misaligned = 1'b0;
            end
            SEW16: begin
                load_elem  = {16'd0, i_read_data[{lane[1], 4'b0000} +: 16]};
                store_word = {2{i_vrf_rdata[15:0]}};
                store_be   = 4'b0011 << lane;
                step       = ADDR_W'(2);
                last_idx   = IDXW'(VLEN/16 - 1);
                misaligned = lane[0];
            end
            default: ;
        endcase
        if (stride_en_q) step = ADDR_W'($signed(stride_q));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_venum == 32'd0 || decode_sew(i_sew) == SEW_BAD) state_next = DONE;
                    else                                                  state_next = RUN;
                end
            end
            RUN:     if (!i_exstall && (misaligned || last_elem)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sew_q       <= SEW8;
            store_q     <= 1'b0;
            stride_en_q <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            stride_q    <= '0;
            venum_q     <= '0;
            cnt_q       <= '0;
            vreg_q      <= '0;
            idx_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sew_q       <= decode_sew(i_sew);
                        store_q     <= i_store;
                        stride_en_q <= i_stride_en;
                        err_q       <= (decode_sew(i_sew) == SEW_BAD);
                        addr_q      <= i_base;
                        stride_q    <= i_stride;
                        venum_q     <= i_venum;
                        cnt_q       <= '0;
                        vreg_q      <= i_vda;
                        idx_q       <= '0;
                    end
                end
                RUN: begin
                    if (!i_exstall) begin
                        if (misaligned) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + step;
                            cnt_q  <= cnt_q + 32'd1;
                            // Register groups wrap silently past v31.
                            if (idx_q == last_idx) begin
                                idx_q  <= '0;
                                vreg_q <= vreg_q + 5'd1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (state == IDLE) ? i_start : 1'b1;
    assign o_done       = (state == DONE);
    assign o_err        = o_done && err_q;
    assign o_read_en    = fire && !store_q;
    assign o_vrf_we     = o_read_en;
    assign o_write_en   = fire && store_q;
    assign o_memaddr    = run ? addr_q : '0;
    assign o_vrf_reg    = run ? vreg_q : '0;
    assign o_vrf_idx    = run ? idx_q : '0;
    assign o_write_data = o_write_en ? store_word : '0;
    assign o_byte_en    = o_write_en ? store_be : '0;
    assign o_vrf_wdata  = o_read_en ? load_elem : '0;

endmodule

// File: tb/tb_vector_lsu.sv
// Scoreboard bench for vector_lsu: expected accesses are queued per instruction and
// popped as the DUT asserts its enables; done timing and error flag are checked too.
module tb_vector_lsu;

    localparam int VLEN   = 128;
    localparam int ADDR_W = 32;
    localparam int IDXW   = $clog2(VLEN/8);

    typedef struct packed {
        logic            rd;
        logic            wr;
        logic            vwe;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [3:0]      be;
        logic [4:0]      vreg;
        logic [IDXW-1:0] idx;
        logic [31:0]     vwdata;
    } acc_t;

    logic              clk = 1'b0;
    logic              rst, start, store, stride_en, exstall;
    logic [ADDR_W-1:0] base;
    logic [31:0]       stride, venum;
    logic [10:0]       sew;
    logic [4:0]        vda;
    logic              busy, done, err, read_en, write_en, vrf_we;
    logic [ADDR_W-1:0] memaddr;
    logic [31:0]       write_data, read_data, vrf_wdata, vrf_rdata;
    logic [3:0]        byte_en;
    logic [4:0]        vrf_reg;
    logic [IDXW-1:0]   vrf_idx;
    logic [10:0]       cur_sew = 11'h020;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] vrf_elem(input logic [4:0] r, input logic [IDXW-1:0] i,
                                             input logic [10:0] s);
        logic [31:0] v;
        v = 32'h1357_9BDF ^ (32'(r) << 24) ^ (32'(i) << 4) ^ (32'(i) << 17) ^ 32'(r);
        if (s == 11'h008)      vrf_elem = v & 32'h0000_00FF;
        else if (s == 11'h010) vrf_elem = v & 32'h0000_FFFF;
        else                   vrf_elem = v;
    endfunction

    assign read_data = mem_word({memaddr[31:2], 2'b00});
    assign vrf_rdata = vrf_elem(vrf_reg, vrf_idx, cur_sew);

    vector_lsu #(.VLEN(VLEN), .ADDR_W(ADDR_W), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_store(store), .i_stride_en(stride_en),
        .i_base(base), .i_stride(stride), .i_sew(sew), .i_venum(venum), .i_vda(vda),
        .i_exstall(exstall), .o_busy(busy), .o_done(done), .o_err(err),
        .o_read_en(read_en), .o_write_en(write_en), .o_memaddr(memaddr),
        .o_write_data(write_data), .o_byte_en(byte_en), .i_read_data(read_data),
        .o_vrf_reg(vrf_reg), .o_vrf_idx(vrf_idx), .o_vrf_we(vrf_we),
        .o_vrf_wdata(vrf_wdata), .i_vrf_rdata(vrf_rdata)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        all_outputs = 128'({busy, done, err, read_en, write_en, memaddr, write_data, byte_en,
                            vrf_reg, vrf_idx, vrf_we, vrf_wdata});
    endfunction

    task automatic run_op(input string name, input logic st, input logic sen,
                          input logic [31:0] b, input logic [31:0] strd, input logic [10:0] s,
                          input logic [31:0] n, input logic [4:0] vd,
                          input int stall_lo, input int stall_hi, input int rst_cyc);
        acc_t        q[$];
        acc_t        e, o;
        logic [31:0] a, w, v, elem;
        logic [4:0]  r;
        logic [IDXW-1:0] i;
        logic        exp_err, mis, legal, finished;
        int          moved, exp_done, bytes, last;

        // Reference model: build the expected access list and completion cycle.
        legal   = (s == 11'h008) || (s == 11'h010) || (s == 11'h020);
        exp_err = !legal;
        mis     = 1'b0;
        moved   = 0;
        a = b; r = vd; i = '0;
        if (legal) begin
            bytes = int'(s) / 8;
            last  = VLEN / int'(s) - 1;
            for (int k = 0; k < int'(n); k++) begin
                if ((bytes == 2 && a[0]) || (bytes == 4 && a[1:0] != 2'b00)) begin
                    mis = 1'b1;
                    exp_err = 1'b1;
                    break;
                end
                e = '0;
                e.addr = a; e.vreg = r; e.idx = i;
                if (st) begin
                    v = vrf_elem(r, i, s);
                    e.wr = 1'b1;
                    case (bytes)
                        1:       begin e.wdata = {4{v[7:0]}};  e.be = 4'b0001 << a[1:0]; end
                        2:       begin e.wdata = {2{v[15:0]}}; e.be = 4'b0011 << a[1:0]; end
                        default: begin e.wdata = v;            e.be = 4'b1111;           end
                    endcase
                end else begin
                    w = mem_word({a[31:2], 2'b00});
                    case (bytes)
                        1:       elem = (w >> (8 * a[1:0])) & 32'h0000_00FF;
                        2:       elem = (w >> (16 * a[1])) & 32'h0000_FFFF;
                        default: elem = w;
                    endcase
                    e.rd = 1'b1; e.vwe = 1'b1; e.vwdata = elem;
                end
                q.push_back(e);
                moved++;
                a = sen ? a + strd : a + 32'(bytes);
                if (int'(i) == last) begin i = '0; r = r + 5'd1; end
                else i = i + 1'b1;
            end
        end
        exp_done = moved + 1 + (mis ? 1 : 0);
        if (stall_lo > 0 && stall_hi >= stall_lo) exp_done += stall_hi - stall_lo + 1;

        @(negedge clk);
        store = st; stride_en = sen; base = b; stride = strd; sew = s; venum = n; vda = vd;
        cur_sew = s; start = 1'b1;
        #1 check({name, " busy_at_start"}, 128'(busy), 128'(1));

        finished = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start   = 1'b0;
            exstall = (cyc >= stall_lo && cyc <= stall_hi);
            if (cyc == rst_cyc) rst = 1'b1;
            #1;
            o = {read_en, write_en, vrf_we, memaddr, write_data, byte_en, vrf_reg, vrf_idx, vrf_wdata};
            check($sformatf("%s busy c%0d", name, cyc), 128'(busy), 128'(1));
            if (exstall) begin
                check($sformatf("%s stall_en c%0d", name, cyc), 128'({read_en, write_en, vrf_we}), 128'(0));
                if (q.size() > 0)
                    check($sformatf("%s stall_addr c%0d", name, cyc), 128'(memaddr), 128'(q[0].addr));
            end else if (read_en || write_en || vrf_we) begin
                if (q.size() == 0) begin
                    check($sformatf("%s unexpected_access c%0d", name, cyc),
                          128'({read_en, write_en, vrf_we}), 128'(0));
                end else begin
                    e = q.pop_front();
                    check($sformatf("%s access c%0d", name, cyc), 128'(o), 128'(e));
                end
            end
            if (cyc == rst_cyc) begin
                @(negedge clk);
                rst = 1'b0;
                #1 check({name, " outputs_after_reset"}, all_outputs(), 128'(0));
                q.delete();
                return;
            end
            if (done) begin
                check({name, " done_cycle"}, 128'(cyc), 128'(exp_done));
                check({name, " err"}, 128'(err), 128'(exp_err));
                check({name, " leftover"}, 128'(q.size()), 128'(0));
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check({name, " done_timeout"}, 128'(done), 128'(1));
        @(negedge clk);
        #1 check({name, " idle_after"}, 128'({busy, done, read_en, write_en, vrf_we}), 128'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; store = 1'b0; stride_en = 1'b0; exstall = 1'b0;
        base = '0; stride = '0; sew = 11'h020; venum = '0; vda = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("reset_outputs", all_outputs(), 128'(0));

        //     name           st    sen   base          stride        sew     venum   vd     stall   rst
        run_op("unit_load",   1'b0, 1'b0, 32'h0000_0100, 32'd0,       11'h020, 32'd4,  5'd2,  0, 0, 0);
        run_op("stride_st",   1'b1, 1'b1, 32'h0000_0201, 32'd3,       11'h008, 32'd5,  5'd7,  0, 0, 0);
        run_op("group_wrap",  1'b0, 1'b0, 32'h0000_0300, 32'd0,       11'h010, 32'd10, 5'd4,  0, 0, 0);
        run_op("stall_load",  1'b0, 1'b0, 32'h0000_0400, 32'd0,       11'h020, 32'd4,  5'd1,  2, 3, 0);
        run_op("misaligned",  1'b0, 1'b0, 32'h0000_0102, 32'd0,       11'h020, 32'd4,  5'd3,  0, 0, 0);
        run_op("venum_zero",  1'b0, 1'b0, 32'h0000_0100, 32'd0,       11'h020, 32'd0,  5'd3,  0, 0, 0);
        run_op("bad_sew",     1'b1, 1'b0, 32'h0000_0100, 32'd0,       11'h018, 32'd3,  5'd3,  0, 0, 0);
        run_op("neg_stride",  1'b1, 1'b1, 32'h0000_0600, 32'hFFFF_FFF8, 11'h020, 32'd6, 5'd31, 0, 0, 0);
        run_op("mid_misalig", 1'b0, 1'b1, 32'h0000_0700, 32'd3,       11'h010, 32'd4,  5'd6,  0, 0, 0);
        run_op("half_store",  1'b1, 1'b1, 32'h0000_0A02, 32'd6,       11'h010, 32'd5,  5'd9,  3, 3, 0);
        run_op("reset_mid",   1'b1, 1'b0, 32'h0000_0800, 32'd0,       11'h008, 32'd8,  5'd10, 0, 0, 3);
        run_op("after_reset", 1'b1, 1'b0, 32'h0000_0800, 32'd0,       11'h008, 32'd8,  5'd10, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vector_lsu.md
Name: vector_lsu

Overview:
- Parametrised vector load/store sequencer for the RV32 core with RVV enabled.
- Executes one vector memory instruction per start pulse: unit-stride or constant-stride, SEW 8/16/32, one element per cycle.
- Moves elements between the single 32-bit data-memory port and an element-granular vector register file port.
- Holds o_busy to stall the core PC and adds stall handling, byte enables, register-group wrap and misalignment detection.

Parameters:
- VLEN, 128: vector register width in bits (power of two, ≥32).
- ADDR_W, 32: memory address width.
- IDXW, $clog2(VLEN/8): element-index width inside one vector register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (see Behaviour).
- i_start  in  1  start pulse; sampled only in IDLE.
- i_store  in  1  1 = store, 0 = load; latched at start.
- i_stride_en  in  1  1 = use i_stride, 0 = unit stride; latched at start.
- i_base  in  ADDR_W  base address (rs1); latched at start.
- i_stride  in  32  signed byte stride (rs2); latched at start.
- i_sew  in  11  element width in bits: 0x08, 0x10 or 0x20; latched at start.
- i_venum  in  32  element count; latched at start.
- i_vda  in  5  vd for loads, vs3 for stores; latched at start.
- i_exstall  in  1  external stall; freezes progress.
- o_busy  out  1  = i_start in IDLE, or state != IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done: misaligned abort.
- o_read_en  out  1  memory read enable.
- o_write_en  out  1  memory write enable.
- o_memaddr  out  ADDR_W  element address.
- o_write_data  out  32  store data, lane-replicated.
- o_byte_en  out  4  store byte enables.
- i_read_data  in  32  memory read data, combinational, same cycle as o_read_en.
- o_vrf_reg  out  5  vector register addressed.
- o_vrf_idx  out  IDXW  element index inside o_vrf_reg.
- o_vrf_we  out  1  VRF element write enable (loads).
- o_vrf_wdata  out  32  loaded element, right-aligned, zero-extended.
- i_vrf_rdata  in  32  element at o_vrf_reg/o_vrf_idx, combinational, right-aligned.

Behaviour:
- Reset: rst is synchronous, active-high, on clock clk. Returns to IDLE and drives all outputs to 0. Reset mid-operation aborts immediately: no done pulse, no further accesses.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_start latches all inputs and sets cnt=0, addr=i_base, reg=i_vda, idx=0.
  - Go to RUN. If i_venum==0 or i_sew is not one of 0x08/0x10/0x20, go straight to DONE with o_err=0 (venum 0) or o_err=1 (illegal SEW).
- RUN, i_exstall=0, element aligned (SEW16: addr[0]=0; SEW32: addr[1:0]=0):
  - Load: o_read_en=1, o_vrf_we=1, o_vrf_wdata = element extracted from lane addr[1:0] (SEW8 byte, SEW16 halfword at addr[1]*16).
  - Store: o_write_en=1; o_write_data = {4{byte}}, {2{half}} or the word; o_byte_en = 0001<<addr[1:0], 0011<<addr[1:0], or 1111.
  - Advance: addr += i_stride_en ? stride : SEW/8 (mod 2^ADDR_W); cnt++; idx++.
  - When idx == VLEN/SEW-1: idx=0, reg++ (mod 32; register groups wrap silently).
  - When cnt == venum-1 after the access, go to DONE.
- RUN, misaligned element: no enables that cycle; go to DONE with o_err=1. Elements already transferred remain written.
- RUN, i_exstall=1: all enables 0; addr, cnt, reg and idx held; o_memaddr/o_vrf_* hold the current element.
- DONE: o_done=1 for one cycle; o_err as set; o_busy=1. Return to IDLE next cycle.
- i_start outside IDLE is ignored.
- Latency: N elements with no stall → start edge, N RUN cycles, DONE on cycle N+1.
- Enables are never asserted in IDLE or DONE.

Test Plan:
- Unit-stride load: SEW=0x20, venum=4, base=0x100, vd=2 → reads at 0x100/104/108/10C in cycles 1-4; VRF writes reg2 idx0-3 with the read words; o_done=1, o_err=0 in cycle 5.
- Strided store: SEW=0x08, stride=3, venum=5, base=0x201 → addresses 0x201/204/207/20A/20D; byte_en 0010/0001/1000/0100/0010; write_data = element byte replicated ×4.
- Group wrap: VLEN=128, SEW=0x10, venum=10, vd=4, unit-stride load → elements 0-7 to reg4 idx0-7, elements 8-9 to reg5 idx0-1; addresses step by 2.
- Stall: 4-element load with i_exstall high for 2 cycles while element 1 is presented → no enables during the stall; element 1 address repeats after the stall; o_done is 2 cycles later than unstalled.
- Misaligned: SEW=0x20, base=0x102 → zero enables in cycle 1; o_done=1, o_err=1 in cycle 2. Also venum=0 → o_done in cycle 1 with no access.
- Reset mid-op: assert rst during element 2 of an 8-element store → the next cycle has all outputs 0 and the FSM is IDLE; a new start then runs normally from element 0.
